// File: rtl/wb_pkg.sv
// Shared widths and the queued write-back entry type for the write-back queue.
package wb_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo_mem.sv
// Write-back FIFO storage: two write ports per cycle (port a is older), one head read.
// With WB_FWD_EN defined it also exposes all entries in age order for forwarding.
module wb_fifo_mem
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_a,
  input  wb_entry_t        entry_a,
  input  logic             push_b,
  input  wb_entry_t        entry_b,
  input  logic             pop,
  output wb_entry_t        head_o,
  output logic [CNT_W-1:0] count_o
`ifdef WB_FWD_EN
  ,
  output wb_entry_t        ord_o [DEPTH],
  output logic [DEPTH-1:0] ord_vld_o
`endif
);
  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_b;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    // Port b lands one slot after port a when both push in the same cycle.
    wr_ptr_b = wr_ptr_q + PTR_W'(push_a);
    if (push_a) mem_d[wr_ptr_q] = entry_a;
    if (push_b) mem_d[wr_ptr_b] = entry_b;
    wr_ptr_d = wr_ptr_b + PTR_W'(push_b);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

`ifdef WB_FWD_EN
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ord_o[i]     = mem_q[rd_ptr_q + PTR_W'(i)];
      ord_vld_o[i] = (i < int'(count_q));
    end
  end
`endif
endmodule

// File: rtl/wb_queue.sv
// In-order write-back queue merging ALU and MDU results onto one register-file write port.
// Define WB_FWD_EN to enable pending-write forwarding; otherwise the Fwd* outputs are tied to 0.
module wb_queue
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              AluValid,
  input  logic [REG_W-1:0]  AluReg,
  input  logic [DATA_W-1:0] AluData,
  input  logic              MduValid,
  input  logic [REG_W-1:0]  MduReg,
  input  logic [DATA_W-1:0] MduData,
  output logic              MduReady,
  output logic              RegWrite,
  output logic [REG_W-1:0]  WriteReg,
  output logic [DATA_W-1:0] WriteData,
  input  logic [REG_W-1:0]  ReadReg1,
  input  logic [REG_W-1:0]  ReadReg2,
  output logic              FwdHit1,
  output logic              FwdHit2,
  output logic [DATA_W-1:0] FwdData1,
  output logic [DATA_W-1:0] FwdData2,
  output logic [CNT_W-1:0]  Count,
  output logic              Overflow
);
  // MDU handshake: a transfer completes on a rising edge where MduValid && MduReady;
  // MduReady never looks at MduValid, and the ALU side has no backpressure at all.
  wb_entry_t        head, alu_entry, mdu_entry;
  logic [CNT_W-1:0] count;
  logic             alu_live, alu_accept, alu_drop, mdu_push, pop;
  logic             overflow_q, overflow_d;

  always_comb begin
    alu_entry  = '{dest: AluReg, data: AluData};
    mdu_entry  = '{dest: MduReg, data: MduData};
    alu_live   = AluValid && (AluReg != '0);
    alu_accept = alu_live && (int'(count) < DEPTH);
    alu_drop   = alu_live && (int'(count) >= DEPTH);
    // Readiness ignores the head pop so it depends on occupancy only.
    MduReady   = (int'(count) + int'(alu_accept)) < DEPTH;
    mdu_push   = MduValid && MduReady && (MduReg != '0);
    pop        = (count != '0);
    overflow_d = overflow_q | alu_drop;
  end

  always_ff @(posedge CLK) begin
    if (RST) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

`ifdef WB_FWD_EN
  wb_entry_t        ord [DEPTH];
  logic [DEPTH-1:0] ord_vld;
`endif

  wb_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk      (CLK),
    .rst      (RST),
    .push_a   (alu_accept),
    .entry_a  (alu_entry),
    .push_b   (mdu_push),
    .entry_b  (mdu_entry),
    .pop      (pop),
    .head_o   (head),
    .count_o  (count)
`ifdef WB_FWD_EN
    ,
    .ord_o    (ord),
    .ord_vld_o(ord_vld)
`endif
  );

  // Entries still pending when reset hits are discarded, so no write leaves in that cycle.
  assign RegWrite  = pop && !RST;
  assign WriteReg  = RegWrite ? head.dest : '0;
  assign WriteData = RegWrite ? head.data : '0;
  assign Count     = count;
  assign Overflow  = overflow_q;

`ifdef WB_FWD_EN
  always_comb begin
    FwdHit1  = 1'b0;
    FwdHit2  = 1'b0;
    FwdData1 = '0;
    FwdData2 = '0;
    // Walk oldest to youngest so the youngest match wins.
    for (int i = 0; i < DEPTH; i++) begin
      if (ord_vld[i] && (ReadReg1 != '0) && (ord[i].dest == ReadReg1)) begin
        FwdHit1  = 1'b1;
        FwdData1 = ord[i].data;
      end
      if (ord_vld[i] && (ReadReg2 != '0) && (ord[i].dest == ReadReg2)) begin
        FwdHit2  = 1'b1;
        FwdData2 = ord[i].data;
      end
    end
  end
`else
  logic unused_read_regs;
  assign unused_read_regs = ^{ReadReg1, ReadReg2};
  assign FwdHit1  = 1'b0;
  assign FwdHit2  = 1'b0;
  assign FwdData1 = '0;
  assign FwdData2 = '0;
`endif
endmodule
